// File: rtl/fetch_ctrl_pkg.sv
// Shared types and address-map defaults for the F-stage fetch controller.
// Sits beside the core's other next-PC definitions.
package fetch_ctrl_pkg;

    typedef enum logic {
        FC_RUN  = 1'b0,
        FC_PEND = 1'b1
    } fc_state_t;

    localparam logic [31:0] FC_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] FC_PC_LO    = 32'h0000_3000;
    localparam logic [31:0] FC_PC_HI    = 32'h0000_6ffc;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between the pipeline (hazard unit, D-stage next-PC, IM) and the fetch controller.
interface fetch_ctrl_if;

    logic        stall;
    logic        im_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_ready;
    logic [31:0] pc_F;
    logic [31:0] pc_F_plus4;
    logic        fetch_valid;
    logic        addr_err;
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;

    modport master (
        output stall, im_ready, redirect_valid, redirect_target,
        input  redirect_ready, pc_F, pc_F_plus4, fetch_valid, addr_err, stall_cnt, redir_cnt
    );

    modport slave (
        input  stall, im_ready, redirect_valid, redirect_target,
        output redirect_ready, pc_F, pc_F_plus4, fetch_valid, addr_err, stall_cnt, redir_cnt
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Debug statistics for the fetch controller: held-PC cycles and accepted redirects.
// Both counters wrap silently.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_stall,
    input  logic        inc_redir,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            redir_cnt <= 32'd0;
        end else begin
            if (inc_stall) stall_cnt <= stall_cnt + 32'd1;
            if (inc_redir) redir_cnt <= redir_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage PC owner: chooses hold / +4 / redirect each cycle and parks one redirect
// that arrives while fetch cannot advance.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FC_RESET_PC,
    parameter logic [31:0] PC_LO    = FC_PC_LO,
    parameter logic [31:0] PC_HI    = FC_PC_HI
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    fc_state_t   state;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        err;
    logic        adv;
    logic        accept;
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;

    function automatic logic target_bad(input logic [31:0] t);
        return (t[1:0] != 2'b00) || (t < PC_LO) || (t > PC_HI);
    endfunction

    assign adv    = !bus.stall && bus.im_ready;
    assign accept = bus.redirect_valid && (state == FC_RUN);

    // Pending target drains first; otherwise a fresh redirect beats the +4 step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FC_RUN;
            pc          <= RESET_PC;
            pend_target <= 32'd0;
            err         <= 1'b0;
        end else begin
            case (state)
                FC_RUN: begin
                    if (accept && adv) begin
                        pc <= bus.redirect_target;
                        if (target_bad(bus.redirect_target)) err <= 1'b1;
                    end else if (accept) begin
                        pend_target <= bus.redirect_target;
                        state       <= FC_PEND;
                    end else if (adv) begin
                        pc <= pc + 32'd4;
                    end
                end
                FC_PEND: begin
                    if (adv) begin
                        pc    <= pend_target;
                        state <= FC_RUN;
                        if (target_bad(pend_target)) err <= 1'b1;
                    end
                end
                default: state <= FC_RUN;
            endcase
        end
    end

    fetch_perf_cnt u_perf (
        .clk       (clk),
        .reset     (reset),
        .inc_stall (!adv),
        .inc_redir (accept),
        .stall_cnt (stall_cnt),
        .redir_cnt (redir_cnt)
    );

    assign bus.redirect_ready = (state == FC_RUN);
    assign bus.pc_F           = pc;
    assign bus.pc_F_plus4     = pc + 32'd4;
    assign bus.fetch_valid    = adv;
    assign bus.addr_err       = err;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.redir_cnt      = redir_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC sequencing, parked redirects, address errors, reset.
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_ctrl_if bus_if ();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge and outputs are read one falling edge later.
    task automatic applyStimulus(input logic rst, input logic stl, input logic imr,
                                 input logic rv, input logic [31:0] tgt);
        reset                  = rst;
        bus_if.stall           = stl;
        bus_if.im_ready        = imr;
        bus_if.redirect_valid  = rv;
        bus_if.redirect_target = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_if.stall           = 1'b0;
        bus_if.im_ready        = 1'b1;
        bus_if.redirect_valid  = 1'b0;
        bus_if.redirect_target = 32'd0;
        @(negedge clk);

        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("rst_pc",    bus_if.pc_F, 32'h3004);
        checkOutput("rst_err",   {31'd0, bus_if.addr_err}, 32'd0);
        checkOutput("rst_ready", {31'd0, bus_if.redirect_ready}, 32'd1);
        checkOutput("rst_redir", bus_if.redir_cnt, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("seq_pc",    bus_if.pc_F, 32'h3008);
        checkOutput("seq_plus4", bus_if.pc_F_plus4, 32'h300c);
        checkOutput("seq_stall", bus_if.stall_cnt, 32'd0);

        applyStimulus(0, 0, 1, 1, 32'h3100);
        checkOutput("redir_pc",    bus_if.pc_F, 32'h3100);
        checkOutput("redir_cnt",   bus_if.redir_cnt, 32'd1);
        checkOutput("redir_ready", {31'd0, bus_if.redirect_ready}, 32'd1);

        applyStimulus(0, 1, 1, 1, 32'h3200);
        checkOutput("park_pc",    bus_if.pc_F, 32'h3100);
        checkOutput("park_ready", {31'd0, bus_if.redirect_ready}, 32'd0);
        checkOutput("park_fv",    {31'd0, bus_if.fetch_valid}, 32'd0);
        checkOutput("park_redir", bus_if.redir_cnt, 32'd2);
        applyStimulus(0, 1, 1, 0, 32'd0);
        checkOutput("park2_ready", {31'd0, bus_if.redirect_ready}, 32'd0);
        applyStimulus(0, 1, 1, 1, 32'h3300);
        checkOutput("park3_pc",    bus_if.pc_F, 32'h3100);
        checkOutput("park3_redir", bus_if.redir_cnt, 32'd2);
        checkOutput("park3_stall", bus_if.stall_cnt, 32'd3);
        applyStimulus(0, 0, 1, 1, 32'h3300);
        checkOutput("drain_pc",    bus_if.pc_F, 32'h3200);
        checkOutput("drain_ready", {31'd0, bus_if.redirect_ready}, 32'd1);
        checkOutput("drain_redir", bus_if.redir_cnt, 32'd2);
        checkOutput("drain_stall", bus_if.stall_cnt, 32'd3);
        applyStimulus(0, 0, 1, 1, 32'h3300);
        checkOutput("late_pc",    bus_if.pc_F, 32'h3300);
        checkOutput("late_redir", bus_if.redir_cnt, 32'd3);

        applyStimulus(0, 0, 1, 1, 32'h6ffc);
        checkOutput("hi_pc",  bus_if.pc_F, 32'h6ffc);
        checkOutput("hi_err", {31'd0, bus_if.addr_err}, 32'd0);
        applyStimulus(0, 0, 1, 1, 32'h3002);
        checkOutput("mis_pc",  bus_if.pc_F, 32'h3002);
        checkOutput("mis_err", {31'd0, bus_if.addr_err}, 32'd1);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("mis_step", bus_if.pc_F, 32'h3006);
        applyStimulus(0, 0, 1, 1, 32'h7000);
        checkOutput("oor_pc",  bus_if.pc_F, 32'h7000);
        checkOutput("oor_err", {31'd0, bus_if.addr_err}, 32'd1);
        applyStimulus(0, 0, 1, 1, 32'hffff_fffc);
        checkOutput("top_plus4", bus_if.pc_F_plus4, 32'h0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("wrap_pc",    bus_if.pc_F, 32'h0);
        checkOutput("wrap_redir", bus_if.redir_cnt, 32'd7);

        applyStimulus(0, 0, 0, 1, 32'h3400);
        checkOutput("im_park_ready", {31'd0, bus_if.redirect_ready}, 32'd0);
        checkOutput("im_park_stall", bus_if.stall_cnt, 32'd4);
        applyStimulus(1, 0, 0, 0, 32'd0);
        checkOutput("mid_rst_pc",    bus_if.pc_F, 32'h3000);
        checkOutput("mid_rst_ready", {31'd0, bus_if.redirect_ready}, 32'd1);
        checkOutput("mid_rst_stall", bus_if.stall_cnt, 32'd0);
        checkOutput("mid_rst_redir", bus_if.redir_cnt, 32'd0);
        checkOutput("mid_rst_err",   {31'd0, bus_if.addr_err}, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'd0);
        checkOutput("discard_pc", bus_if.pc_F, 32'h3004);
        applyStimulus(0, 0, 1, 1, 32'h2ffc);
        checkOutput("lo_pc",  bus_if.pc_F, 32'h2ffc);
        checkOutput("lo_err", {31'd0, bus_if.addr_err}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
